// File: rtl/bbox_rasteriser_if.sv
// rtl/bbox_rasteriser_if.sv - triangle-in / pixel-out handshake bundle for bbox_rasteriser
interface bbox_rasteriser_if #(
  parameter int COORD_W = 16,
  parameter int ADDR_W  = 19
);
  logic               tri_valid;
  logic               tri_ready;
  logic [COORD_W-1:0] x1, y1, x2, y2, x3, y3;
  logic               pix_valid;
  logic               pix_ready;
  logic [COORD_W-1:0] pix_x, pix_y;
  logic [ADDR_W-1:0]  pixel_number;
  logic [ADDR_W-1:0]  pix_count;
  logic               tri_done;
  logic               busy;

  // master: triangle source and pixel sink; slave: the rasteriser
  modport master (
    output tri_valid, x1, y1, x2, y2, x3, y3, pix_ready,
    input  tri_ready, pix_valid, pix_x, pix_y, pixel_number, pix_count, tri_done, busy
  );

  modport slave (
    input  tri_valid, x1, y1, x2, y2, x3, y3, pix_ready,
    output tri_ready, pix_valid, pix_x, pix_y, pixel_number, pix_count, tri_done, busy
  );
endinterface

// File: rtl/bbox_rasteriser.sv
// rtl/bbox_rasteriser.sv - bounding-box triangle rasteriser, one candidate pixel per cycle
module bbox_rasteriser #(
  parameter int COORD_W  = 16,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int ADDR_W   = 19,
  parameter int CULL_CW  = 0
) (
  input logic            clk,
  input logic            reset,
  bbox_rasteriser_if.slave bus
);
  localparam int EW = 2 * COORD_W + 3;

  typedef logic [COORD_W-1:0]   coord_t;
  typedef logic signed [EW-1:0] edge_t;
  typedef enum logic [1:0] {IDLE, SETUP, SCAN, DONE} state_t;

  localparam coord_t            X_LAST = coord_t'(SCREEN_W - 1);
  localparam coord_t            Y_LAST = coord_t'(SCREEN_H - 1);
  localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(SCREEN_W);

  state_t            state, state_nx;
  coord_t            vx1, vy1, vx2, vy2, vx3, vy3;
  coord_t            xmin_q, xmax_q, ymin_q, ymax_q;
  coord_t            x_q, y_q;
  logic [ADDR_W-1:0] count_q;

  function automatic edge_t ext(coord_t v);
    return edge_t'({{(EW-COORD_W){1'b0}}, v});
  endfunction

  // Operands are widened first so differences and products never wrap
  function automatic edge_t edge_fn(coord_t ax, coord_t ay, coord_t bx, coord_t by,
                                    coord_t px, coord_t py);
    return (ext(bx) - ext(ax)) * (ext(py) - ext(ay))
         - (ext(by) - ext(ay)) * (ext(px) - ext(ax));
  endfunction

  function automatic coord_t min3(coord_t a, coord_t b, coord_t c);
    coord_t m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  function automatic coord_t max3(coord_t a, coord_t b, coord_t c);
    coord_t m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Setup-time values, derived from the latched vertices
  coord_t bx_lo, bx_hi, by_lo, by_hi;
  coord_t bx_hi_clip, by_hi_clip;
  edge_t  area;
  logic   reject;

  assign bx_lo      = min3(vx1, vx2, vx3);
  assign bx_hi      = max3(vx1, vx2, vx3);
  assign by_lo      = min3(vy1, vy2, vy3);
  assign by_hi      = max3(vy1, vy2, vy3);
  assign bx_hi_clip = (bx_hi > X_LAST) ? X_LAST : bx_hi;
  assign by_hi_clip = (by_hi > Y_LAST) ? Y_LAST : by_hi;
  assign area       = edge_fn(vx1, vy1, vx2, vy2, vx3, vy3);
  assign reject     = (area == '0)
                    || ((CULL_CW != 0) && area[EW-1])
                    || (bx_lo > X_LAST)
                    || (by_lo > Y_LAST);

  // Coverage of the current scan point
  edge_t e1, e2, e3;
  logic  all_nonneg, all_nonpos, covered;
  logic  in_scan, pix_valid, advance, x_end, y_end;

  assign e1 = edge_fn(vx1, vy1, vx2, vy2, x_q, y_q);
  assign e2 = edge_fn(vx2, vy2, vx3, vy3, x_q, y_q);
  assign e3 = edge_fn(vx3, vy3, vx1, vy1, x_q, y_q);

  assign all_nonneg = !e1[EW-1] && !e2[EW-1] && !e3[EW-1];
  assign all_nonpos = (e1[EW-1] || e1 == '0) && (e2[EW-1] || e2 == '0)
                   && (e3[EW-1] || e3 == '0);
  assign covered    = all_nonneg || all_nonpos;

  assign in_scan   = (state == SCAN);
  assign pix_valid = in_scan && covered;
  assign advance   = in_scan && (!covered || bus.pix_ready);
  assign x_end     = (x_q == xmax_q);
  assign y_end     = (y_q == ymax_q);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.tri_valid) state_nx = SETUP;
      SETUP:   state_nx = reject ? DONE : SCAN;
      SCAN:    if (advance && x_end && y_end) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      vx1     <= '0;
      vy1     <= '0;
      vx2     <= '0;
      vy2     <= '0;
      vx3     <= '0;
      vy3     <= '0;
      xmin_q  <= '0;
      xmax_q  <= '0;
      ymin_q  <= '0;
      ymax_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      count_q <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (bus.tri_valid) begin
            vx1     <= bus.x1;
            vy1     <= bus.y1;
            vx2     <= bus.x2;
            vy2     <= bus.y2;
            vx3     <= bus.x3;
            vy3     <= bus.y3;
            count_q <= '0;
          end
        end
        SETUP: begin
          xmin_q <= bx_lo;
          xmax_q <= bx_hi_clip;
          ymin_q <= by_lo;
          ymax_q <= by_hi_clip;
          x_q    <= bx_lo;
          y_q    <= by_lo;
        end
        SCAN: begin
          if (pix_valid && bus.pix_ready) count_q <= count_q + 1'b1;
          // A stalled covered point leaves the counters untouched
          if (advance) begin
            if (x_end) begin
              x_q <= xmin_q;
              if (!y_end) y_q <= y_q + 1'b1;
            end else begin
              x_q <= x_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.tri_ready    = (state == IDLE);
  assign bus.busy         = (state != IDLE);
  assign bus.tri_done     = (state == DONE);
  assign bus.pix_valid    = pix_valid;
  assign bus.pix_x        = x_q;
  assign bus.pix_y        = y_q;
  assign bus.pixel_number = ADDR_W'(y_q) * ROW_STRIDE + ADDR_W'(x_q);
  assign bus.pix_count    = count_q;
endmodule

// File: tb/tb_bbox_rasteriser.sv
// tb/tb_bbox_rasteriser.sv - scoreboard bench: two rasterisers (no cull / cull) against a reference model
module tb_bbox_rasteriser;
  localparam int SW = 640;
  localparam int SH = 480;

  typedef struct {
    int x;
    int y;
    int pn;
  } pix_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bbox_rasteriser_if #(.COORD_W(16), .ADDR_W(19)) b0 ();
  bbox_rasteriser_if #(.COORD_W(16), .ADDR_W(19)) b1 ();

  bbox_rasteriser #(.CULL_CW(0)) u_nocull (.clk(clk), .reset(rst_n), .bus(b0.slave));
  bbox_rasteriser #(.CULL_CW(1)) u_cull   (.clk(clk), .reset(rst_n), .bus(b1.slave));

  pix_t exp_q0[$];
  pix_t exp_q1[$];
  int   tests = 0;
  int   fails = 0;
  int   rdy_mode = 0;
  int   done_cnt[2];
  bit   stall_prev[2];
  int   held_x[2], held_y[2], held_pn[2];
  int   first_pn0, last_pn0, max_pn0, max_x0, max_y0;

  task automatic check(string name, longint act, longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint ef(int ax, int ay, int bx, int by, int px, int py);
    return longint'(bx - ax) * longint'(py - ay) - longint'(by - ay) * longint'(px - ax);
  endfunction

  // Reference: walk the clipped box in raster order, keep points inside or on all three edges
  function automatic int model(int id, int x1, int y1, int x2, int y2, int x3, int y3);
    longint a, e1, e2, e3;
    int xl, xh, yl, yh, n;
    n = 0;
    a = ef(x1, y1, x2, y2, x3, y3);
    if (a == 0 || (id == 1 && a < 0)) return 0;
    xl = (x1 < x2) ? x1 : x2; xl = (xl < x3) ? xl : x3;
    yl = (y1 < y2) ? y1 : y2; yl = (yl < y3) ? yl : y3;
    xh = (x1 > x2) ? x1 : x2; xh = (xh > x3) ? xh : x3;
    yh = (y1 > y2) ? y1 : y2; yh = (yh > y3) ? yh : y3;
    if (xh > SW - 1) xh = SW - 1;
    if (yh > SH - 1) yh = SH - 1;
    if (xl >= SW || yl >= SH) return 0;
    for (int y = yl; y <= yh; y++) begin
      for (int x = xl; x <= xh; x++) begin
        e1 = ef(x1, y1, x2, y2, x, y);
        e2 = ef(x2, y2, x3, y3, x, y);
        e3 = ef(x3, y3, x1, y1, x, y);
        if ((e1 >= 0 && e2 >= 0 && e3 >= 0) || (e1 <= 0 && e2 <= 0 && e3 <= 0)) begin
          if (id == 0) exp_q0.push_back('{x, y, y * SW + x});
          else         exp_q1.push_back('{x, y, y * SW + x});
          n++;
        end
      end
    end
    return n;
  endfunction

  task automatic mon(int id, logic v, logic r, int x, int y, int pn, logic done);
    pix_t e;
    int   qs;
    if (stall_prev[id]) begin
      check($sformatf("d%0d_stall_valid", id), longint'(v), 1);
      check($sformatf("d%0d_stall_x", id), x, held_x[id]);
      check($sformatf("d%0d_stall_y", id), y, held_y[id]);
      check($sformatf("d%0d_stall_pn", id), pn, held_pn[id]);
    end
    if (v && r) begin
      qs = (id == 0) ? exp_q0.size() : exp_q1.size();
      if (qs == 0) begin
        check($sformatf("d%0d_unexpected_pixel_at_%0d_%0d", id, x, y), 1, 0);
      end else begin
        e = (id == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        check($sformatf("d%0d_pix_x", id), x, e.x);
        check($sformatf("d%0d_pix_y", id), y, e.y);
        check($sformatf("d%0d_pixel_number", id), pn, e.pn);
      end
      if (id == 0) begin
        if (first_pn0 < 0) first_pn0 = pn;
        last_pn0 = pn;
        if (pn > max_pn0) max_pn0 = pn;
        if (x > max_x0) max_x0 = x;
        if (y > max_y0) max_y0 = y;
      end
    end
    stall_prev[id] = v && !r;
    held_x[id] = x;
    held_y[id] = y;
    held_pn[id] = pn;
    if (done) done_cnt[id]++;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        mon(0, b0.pix_valid, b0.pix_ready, int'(b0.pix_x), int'(b0.pix_y),
            int'(b0.pixel_number), b0.tri_done);
        mon(1, b1.pix_valid, b1.pix_ready, int'(b1.pix_x), int'(b1.pix_y),
            int'(b1.pixel_number), b1.tri_done);
      end else begin
        stall_prev[0] = 1'b0;
        stall_prev[1] = 1'b0;
      end
    end
  end

  initial begin
    b0.pix_ready = 1'b1;
    b1.pix_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       b0.pix_ready = 1'b1;
        1:       b0.pix_ready = ~b0.pix_ready;
        default: b0.pix_ready = 1'($urandom % 2);
      endcase
      b1.pix_ready = b0.pix_ready;
    end
  end

  task automatic drive_tri(logic v, int x1, int y1, int x2, int y2, int x3, int y3);
    b0.tri_valid = v; b1.tri_valid = v;
    b0.x1 = 16'(x1); b0.y1 = 16'(y1); b0.x2 = 16'(x2);
    b0.y2 = 16'(y2); b0.x3 = 16'(x3); b0.y3 = 16'(y3);
    b1.x1 = 16'(x1); b1.y1 = 16'(y1); b1.x2 = 16'(x2);
    b1.y2 = 16'(y2); b1.x3 = 16'(x3); b1.y3 = 16'(y3);
  endtask

  task automatic accept(int x1, int y1, int x2, int y2, int x3, int y3);
    drive_tri(1'b1, x1, y1, x2, y2, x3, y3);
    @(negedge clk);
    check("tri_ready_before_accept", longint'(b0.tri_ready && b1.tri_ready), 1);
    @(posedge clk);
    #1;
    // garbage on the coordinate bus once the handshake is over
    drive_tri(1'b0, $urandom % 1000, $urandom % 1000, $urandom % 1000,
              $urandom % 1000, $urandom % 1000, $urandom % 1000);
  endtask

  task automatic send(int x1, int y1, int x2, int y2, int x3, int y3, bit chk_lat);
    int n0, n1, d0, d1, fv, n, dc0, dc1;
    d0 = -1; d1 = -1; fv = -1; n = 0;
    dc0 = done_cnt[0];
    dc1 = done_cnt[1];
    n0 = model(0, x1, y1, x2, y2, x3, y3);
    n1 = model(1, x1, y1, x2, y2, x3, y3);
    accept(x1, y1, x2, y2, x3, y3);
    while ((d0 < 0 || d1 < 0) && n < 20000) begin
      @(negedge clk);
      n++;
      if (b0.tri_done && d0 < 0) d0 = n;
      if (b1.tri_done && d1 < 0) d1 = n;
      if (b0.pix_valid && fv < 0) fv = n;
    end
    if (d0 < 0 || d1 < 0) check("tri_done_timeout", 0, 1);
    if (chk_lat) begin
      if (n0 > 0) check("first_pixel_latency", fv, 2);
      else        check("done_latency", d0, 2);
    end
    repeat (2) @(negedge clk);
    check("d0_one_done_pulse", done_cnt[0], dc0 + 1);
    check("d1_one_done_pulse", done_cnt[1], dc1 + 1);
    check("d0_pix_count", longint'(b0.pix_count), n0);
    check("d1_pix_count", longint'(b1.pix_count), n1);
    check("d0_missing_pixels", exp_q0.size(), 0);
    check("d1_missing_pixels", exp_q1.size(), 0);
    check("d0_back_to_idle", longint'(b0.tri_ready && !b0.busy), 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int bx, by;
    done_cnt = '{0, 0};
    stall_prev = '{0, 0};
    drive_tri(1'b0, 0, 0, 0, 0, 0, 0);
    first_pn0 = -1; last_pn0 = -1; max_pn0 = -1; max_x0 = -1; max_y0 = -1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_pix_valid", longint'(b0.pix_valid), 0);
    check("rst_busy", longint'(b0.busy), 0);
    check("rst_tri_done", longint'(b0.tri_done), 0);
    check("rst_pixel_number", longint'(b0.pixel_number), 0);
    check("rst_pix_count", longint'(b0.pix_count), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("tri_ready_after_reset", longint'(b0.tri_ready), 1);
    @(posedge clk);
    #1;

    // Right triangle, full-rate sink; culling instance sees positive area too
    rdy_mode = 0;
    first_pn0 = -1;
    send(0, 0, 3, 0, 0, 3, 1'b1);
    check("basic_count_10", longint'(b0.pix_count), 10);
    check("basic_first_pn", first_pn0, 0);
    check("basic_last_pn", last_pn0, 1920);

    rdy_mode = 1;
    send(0, 0, 3, 0, 0, 3, 1'b1);
    rdy_mode = 0;

    send(0, 0, 2, 2, 4, 4, 1'b1);
    check("degenerate_count", longint'(b0.pix_count), 0);

    // Clockwise winding: culled on one instance only
    send(0, 0, 0, 3, 3, 0, 1'b1);
    check("cw_nocull_count", longint'(b0.pix_count), 10);
    check("cw_cull_count", longint'(b1.pix_count), 0);

    max_pn0 = -1; max_x0 = -1; max_y0 = -1;
    send(630, 470, 700, 470, 630, 500, 1'b0);
    check("clip_max_x", max_x0, 639);
    check("clip_max_y", max_y0, 479);
    check("clip_max_pn", max_pn0, 307199);

    // Abort mid-scan with a stalling sink
    rdy_mode = 1;
    void'(model(0, 0, 0, 3, 0, 0, 3));
    void'(model(1, 0, 0, 3, 0, 0, 3));
    accept(0, 0, 3, 0, 0, 3);
    repeat (5) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_pix_valid", longint'(b0.pix_valid), 0);
    check("abort_busy", longint'(b0.busy), 0);
    check("abort_tri_done", longint'(b0.tri_done), 0);
    check("abort_pix_x", longint'(b0.pix_x), 0);
    check("abort_pix_y", longint'(b0.pix_y), 0);
    check("abort_pixel_number", longint'(b0.pixel_number), 0);
    check("abort_pix_count", longint'(b0.pix_count), 0);
    exp_q0.delete();
    exp_q1.delete();
    begin
      int dc;
      dc = done_cnt[0];
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("abort_tri_ready", longint'(b0.tri_ready), 1);
      repeat (3) @(negedge clk);
      check("abort_no_done", done_cnt[0], dc);
    end
    @(posedge clk);
    #1;
    rdy_mode = 0;
    send(0, 0, 3, 0, 0, 3, 1'b1);

    for (int i = 0; i < 24; i++) begin
      rdy_mode = int'($urandom % 3);
      if (i % 4 == 3) begin
        bx = 620; by = 460;
      end else begin
        bx = 0; by = 0;
      end
      send(bx + int'($urandom % 30), by + int'($urandom % 30),
           bx + int'($urandom % 30), by + int'($urandom % 30),
           bx + int'($urandom % 30), by + int'($urandom % 30), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/bbox_rasteriser.md
BBOX_RASTERISER -- requirements
Module: bbox_rasteriser

Parameters
REQ-001 COORD_W, default 16, vertex coordinate width, unsigned.
REQ-002 SCREEN_W, default 640, screen width in pixels.
REQ-003 SCREEN_H, default 480, screen height in pixels.
REQ-004 ADDR_W, default 19, pixel_number width; must satisfy 2^ADDR_W >= SCREEN_W*SCREEN_H.
REQ-005 CULL_CW, default 0; 0 rasterises both windings, 1 discards triangles with negative signed area.

Interface
REQ-006 Single clock; reset is asynchronous and active-low; ports named clk and reset.
REQ-007 clk  in  1  rising-edge clock.
REQ-008 reset  in  1  asynchronous active-low reset.
REQ-009 tri_valid  in  1  triangle vertices valid.
REQ-010 tri_ready  out  1  block accepts a triangle (high only in IDLE).
REQ-011 x1,y1,x2,y2,x3,y3  in  COORD_W each  vertex coordinates.
REQ-012 pix_valid  out  1  pix_x/pix_y/pixel_number hold a covered pixel.
REQ-013 pix_ready  in  1  downstream accepts the pixel.
REQ-014 pix_x, pix_y  out  COORD_W each  pixel coordinates.
REQ-015 pixel_number  out  ADDR_W  linear address pix_y*SCREEN_W + pix_x.
REQ-016 pix_count  out  ADDR_W  pixels handed off for the current/last triangle.
REQ-017 tri_done  out  1  one-cycle pulse on triangle completion.
REQ-018 busy  out  1  high in any state other than IDLE.

Function
REQ-019 States: IDLE, SETUP, SCAN, DONE; any other encoding goes to IDLE.
REQ-020 IDLE: tri_valid & tri_ready latches all six coordinates, clears pix_count, goes to SETUP; inputs are ignored outside that handshake.
REQ-021 SETUP (one cycle): bbox = min/max of the vertices, clipped to [0,SCREEN_W-1] x [0,SCREEN_H-1]; signed area A = E(v1,v2,v3).
REQ-022 SETUP exit: DONE if A==0, if CULL_CW==1 and A<0, or if the clipped bbox is empty (xmin>=SCREEN_W or ymin>=SCREEN_H); otherwise SCAN with x=xmin, y=ymin.
REQ-023 Edge function: E(a,b,p) = (bx-ax)*(py-ay) - (by-ay)*(px-ax), evaluated signed at 2*COORD_W+3 bits with no overflow.
REQ-024 Coverage: p is covered when E(v1,v2,p), E(v2,v3,p) and E(v3,v1,p) are all >=0, or all <=0; pixels on edges and vertices are covered.
REQ-025 SCAN visits the bbox in raster order: x increments to xmax, then x=xmin and y+1; one point per cycle when no stall.
REQ-026 pix_valid = (state==SCAN) & covered(current point); point outputs derive from registered counters only.
REQ-027 Stall: while pix_valid & !pix_ready, the counters and all pix_* outputs hold stable.
REQ-028 Advance: on an uncovered point, or on pix_valid & pix_ready; pix_count increments on each handshake.
REQ-029 After the point (xmax,ymax) advances, the next state is DONE.
REQ-030 DONE: tri_done=1 for exactly one cycle, then IDLE; pix_count holds until the next accept.
REQ-031 Accept-to-first-point latency: 2 cycles (accept edge -> SETUP -> SCAN).
REQ-032 pixel_number is truncated to ADDR_W bits; it never exceeds SCREEN_W*SCREEN_H-1 because of clipping.

Reset
REQ-033 With reset low: state=IDLE, pix_valid=0, tri_done=0, busy=0, pix_x=pix_y=0, pixel_number=0, pix_count=0, latched vertices=0.
REQ-034 Reset asserted mid-SCAN or mid-stall aborts the triangle immediately; no tri_done is produced.
REQ-035 tri_ready=1 in the first cycle after reset deasserts.

Verification
REQ-036 Vertices (0,0),(3,0),(0,3), pix_ready=1 -> 10 pixels in order (0..3,0),(0..2,1),(0..1,2),(0,3); first pixel_number=0, last=1920; pix_count=10; one tri_done pulse.
REQ-037 Same triangle with pix_ready toggled every other cycle -> identical pixel sequence with no drops or duplicates; outputs stable during each stall.
REQ-038 Degenerate (0,0),(2,2),(4,4) -> no pix_valid; tri_done 2 cycles after accept; pix_count=0.
REQ-039 Vertices (630,470),(700,470),(630,500) -> no pixel with pix_x>639 or pix_y>479; pixel_number max 479*640+639=307199.
REQ-040 CULL_CW=1 with (0,0),(0,3),(3,0) -> 0 pixels and tri_done; CULL_CW=0 -> the same 10 pixels as REQ-036.
REQ-041 reset pulsed low during SCAN of REQ-036 -> all outputs go to reset values; a new triangle afterwards rasterises correctly.
